// File: rtl/if_stage_unit.sv
// Purpose : instruction-fetch stage; one fetch in flight, a skid slot holds a response captured during a freeze.
// Latency : one clk edge from an accepted imem response (no hazard) to if_id_valid=1.
// Backpr. : hazard_detected freezes IF/ID; a same-cycle response is parked in the skid slot and fetch pauses (HOLD).
//
// Ports:
//   clk, rst (async, active-low)
//   hazard_detected      - freeze request from hazard unit
//   branch_taken/_addr   - redirect from EXE, highest priority
//   imem_req/imem_addr   - fetch request and word-aligned address
//   imem_ready/_rdata    - response strobe and instruction, same cycle
//   if_id_pc/_instr/_valid - IF/ID pipeline register (pc is PC+4 of held instr)
module if_stage_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_detected,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  // PC is kept word-aligned in the register itself, so imem_addr is a straight copy.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] skid_pc_q;
  logic [31:0] skid_instr_q;
  logic [31:0] if_id_pc_q;
  logic [31:0] if_id_instr_q;
  logic        if_id_valid_q;

  logic [31:0] pc_plus4;
  logic        unused_branch_lsbs;

  // Wraps modulo 2^32 naturally.
  assign pc_plus4 = pc_q + 32'd4;

  // Redirect targets are forced to word alignment; the low bits carry no meaning.
  assign unused_branch_lsbs = ^branch_addr[1:0];

  assign imem_addr   = pc_q;
  // Gating with rst keeps the request low during reset even though state already reads FETCH.
  assign imem_req    = rst && (state_q == FETCH);
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC_ALIGNED;
      skid_pc_q     <= 32'h0;
      skid_instr_q  <= 32'h0;
      if_id_pc_q    <= 32'h0;
      if_id_instr_q <= 32'h0;
      if_id_valid_q <= 1'b0;
    end else if (branch_taken) begin
      // Flush: drop any response this cycle and any parked instruction.
      state_q       <= FETCH;
      pc_q          <= {branch_addr[31:2], 2'b00};
      skid_pc_q     <= 32'h0;
      skid_instr_q  <= 32'h0;
      if_id_instr_q <= 32'h0;
      if_id_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (imem_ready) begin
            pc_q <= pc_plus4;
            if (hazard_detected) begin
              // ID cannot take it now; park it and stop fetching.
              skid_pc_q    <= pc_plus4;
              skid_instr_q <= imem_rdata;
              state_q      <= HOLD;
            end else begin
              if_id_pc_q    <= pc_plus4;
              if_id_instr_q <= imem_rdata;
              if_id_valid_q <= 1'b1;
            end
          end else if (!hazard_detected) begin
            // Memory stall with ID free: insert a bubble, keep the old pc field.
            if_id_instr_q <= 32'h0;
            if_id_valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (!hazard_detected) begin
            if_id_pc_q    <= skid_pc_q;
            if_id_instr_q <= skid_instr_q;
            if_id_valid_q <= 1'b1;
            state_q       <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

endmodule

// File: doc/if_stage_unit.md
IF_STAGE_UNIT -- requirements
Module: if_stage_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port hazard_detected  input  1  freeze request from the hazard detection unit.
REQ-005 SHALL have port branch_taken  input  1  redirect request from EXE.
REQ-006 SHALL have port branch_addr  input  32  redirect target.
REQ-007 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-008 SHALL have port imem_addr  output  32  fetch address.
REQ-009 SHALL have port imem_ready  input  1  response strobe; imem_rdata is valid in the same cycle.
REQ-010 SHALL have port imem_rdata  input  32  fetched instruction.
REQ-011 SHALL have port if_id_pc  output  32  registered PC+4 of the held instruction.
REQ-012 SHALL have port if_id_instr  output  32  registered instruction to ID.
REQ-013 SHALL have port if_id_valid  output  1  if_id_instr holds a real instruction (0 = bubble).

Function
REQ-014 SHALL hold internal registers: PC (32 bits), FSM state in {FETCH, HOLD}, skid buffer (instr, pc+4), and the IF/ID register.
REQ-015 SHALL drive imem_addr = {PC[31:2], 2'b00} combinationally.
REQ-016 SHALL drive imem_req = 1 in FETCH and 0 in HOLD.
REQ-017 SHALL apply the following in FETCH when imem_ready=1, hazard_detected=0 and branch_taken=0: IF/ID <= {PC+4, imem_rdata, valid=1}, PC <= PC+4, state stays FETCH.
REQ-018 SHALL apply the following in FETCH when imem_ready=1, hazard_detected=1 and branch_taken=0: skid buffer <= {PC+4, imem_rdata}, PC <= PC+4, IF/ID unchanged, state -> HOLD.
REQ-019 SHALL apply the following in FETCH when imem_ready=0, hazard_detected=0 and branch_taken=0: IF/ID <= bubble (pc unchanged, instr=32'h0, valid=0), PC unchanged.
REQ-020 SHALL apply the following in FETCH when imem_ready=0, hazard_detected=1 and branch_taken=0: IF/ID and PC unchanged.
REQ-021 SHALL apply the following in HOLD when branch_taken=0: while hazard_detected=1 nothing changes; on the first cycle hazard_detected=0, IF/ID <= {skid buffer, valid=1} and state -> FETCH; the fetch resumes at the following edge.
REQ-022 SHALL give branch_taken=1 priority over all other inputs in any state: PC <= {branch_addr[31:2],2'b00}, IF/ID <= bubble, skid buffer discarded, any same-cycle imem response discarded, state -> FETCH.
REQ-023 SHALL wrap PC+4 modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000) with no flag.
REQ-024 SHALL never lose or duplicate an instruction across a freeze: every response accepted is presented on IF/ID exactly once unless flushed by branch_taken.
REQ-025 SHALL have a latency of one edge from an accepted imem response (hazard_detected=0) to if_id_valid=1.

Reset
REQ-026 SHALL asynchronously set, while rst=0: PC=RESET_PC, state=FETCH, if_id_pc=0, if_id_instr=0, if_id_valid=0, and skid buffer cleared.
REQ-027 SHALL hold imem_req=0 while rst=0.
REQ-028 SHALL start fetching at RESET_PC on the first rising edge after rst deasserts.
REQ-029 SHALL abandon in-progress HOLD or skid contents on reset mid-operation.

Verification
REQ-030 SHALL cover streaming: imem_ready=1 every cycle, instrs A,B,C at 0,4,8 -> IF/ID shows {4,A},{8,B},{12,C} on consecutive cycles, valid=1.
REQ-031 SHALL cover a freeze with a captured response: hazard=1 for 3 cycles while the response D at PC=0x10 arrives -> state HOLD, imem_req=0, IF/ID unchanged; one cycle after hazard drops IF/ID={0x14,D}, then the fetch at 0x14.
REQ-032 SHALL cover a simultaneous branch and hazard: branch_taken=1, branch_addr=0x103, hazard=1, imem_ready=1 -> PC=0x100, if_id_valid=0, the response dropped, the next imem_addr=0x100.
REQ-033 SHALL cover memory stall: imem_ready=0 for 2 cycles with hazard=0 -> two bubbles (valid=0, instr=0), PC held, imem_addr constant.
REQ-034 SHALL cover wrap: PC=32'hFFFF_FFFC with an accepted response -> if_id_pc=0, next imem_addr=0.
REQ-035 SHALL cover reset while in HOLD: rst=0 for one cycle -> all outputs zero immediately, then a fetch from RESET_PC; the buffered instruction is never presented.
